// File: rtl/fb_pkg.sv
// Shared constants, command encodings and FSM states for the double-buffered frame store.
package fb_pkg;

    localparam int unsigned FB_W     = 128;
    localparam int unsigned FB_H     = 64;
    localparam int unsigned FB_BYTES = 1024;
    localparam int unsigned FB_AW    = 10;

    typedef enum logic [2:0] {
        OpSet    = 3'd0,
        OpClr    = 3'd1,
        OpToggle = 3'd2,
        OpFill   = 3'd3,
        OpSwap   = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRd,
        StWr,
        StFill,
        StSwapWait
    } state_e;

    // SSD1306 vertical addressing: one byte covers 8 rows of one column
    function automatic logic [FB_AW-1:0] pix_addr(input logic [6:0] x, input logic [5:0] y);
        return {x, y[5:3]};
    endfunction

endpackage

// File: rtl/fb_dp_ram.sv
// 1024x8 simple dual-port RAM: one write port, one registered read port.
module fb_dp_ram
    import fb_pkg::*;
#(
    parameter int unsigned Depth = FB_BYTES,
    parameter int unsigned Aw    = FB_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [Aw-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [Aw-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register reset maps onto the block-RAM output latch reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered 128x64 monochrome frame store; display reads the front bank while
// pixel/fill commands modify the back bank, and banks swap only at a frame boundary.
module frame_buffer
    import fb_pkg::*;
#(
    parameter logic [7:0] INIT_FILL  = 8'h00,
    parameter bit         AUTO_CLEAR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [6:0] cmd_x,
    input  logic [5:0] cmd_y,
    input  logic [7:0] cmd_fill,
    output logic       front_bank,
    output logic       frame_tick,
    output logic       busy
);

    localparam logic [FB_AW-1:0] LastAddr = FB_AW'(FB_BYTES - 1);

    state_e           state_q;
    logic [FB_AW-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [6:0]       x_q;
    logic [5:0]       y_q;
    logic [7:0]       fill_q;
    logic             front_q, ready_q, busy_q;
    logic [FB_AW-1:0] prev_addr_q;
    logic             tick_q, rd_sel_q;

    logic [FB_AW-1:0] rmw_addr, waddr, raddr0, raddr1;
    logic [7:0]       rdata0, rdata1, back_rdata, mask, mod_byte, wdata;
    logic             we_both, we_back, we0, we1;

    // Boundary detector; rd_sel_q remembers which bank served the read in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_addr_q <= '0;
            tick_q      <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            prev_addr_q <= rd_addr;
            tick_q      <= (prev_addr_q == LastAddr) && (rd_addr == '0);
            rd_sel_q    <= front_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fill_q  <= INIT_FILL;
            front_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StInit, StFill: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastAddr) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StIdle: begin
                    if (cmd_valid && ready_q) begin
                        op_q   <= cmd_op;
                        x_q    <= cmd_x;
                        y_q    <= cmd_y;
                        fill_q <= cmd_fill;
                        if (cmd_op <= OpSwap) begin
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                        case (cmd_op)
                            OpSet, OpClr, OpToggle: state_q <= StRd;
                            OpFill:                 state_q <= StFill;
                            OpSwap:                 state_q <= StSwapWait;
                            default:                state_q <= StIdle;
                        endcase
                    end
                end
                StRd: state_q <= StWr;
                StWr: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                StSwapWait: begin
                    if (tick_q) begin
                        front_q <= ~front_q;
                        if (AUTO_CLEAR) begin
                            fill_q  <= INIT_FILL;
                            cnt_q   <= '0;
                            state_q <= StFill;
                        end else begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign rmw_addr   = pix_addr(x_q, y_q);
    assign back_rdata = front_q ? rdata0 : rdata1;
    assign mask       = 8'd1 << y_q[2:0];

    always_comb begin
        mod_byte = back_rdata ^ mask;
        we_both  = 1'b0;
        we_back  = 1'b0;
        waddr    = cnt_q;
        wdata    = fill_q;
        if (op_q == OpSet) begin
            mod_byte = back_rdata | mask;
        end else if (op_q == OpClr) begin
            mod_byte = back_rdata & ~mask;
        end
        case (state_q)
            StInit: begin
                we_both = 1'b1;
                wdata   = INIT_FILL;
            end
            StFill: we_back = 1'b1;
            StWr: begin
                we_back = 1'b1;
                waddr   = rmw_addr;
                wdata   = mod_byte;
            end
            default: ;
        endcase
    end

    // Writes only ever reach the back bank, except during INIT
    assign we0    = we_both | (we_back & front_q);
    assign we1    = we_both | (we_back & ~front_q);
    assign raddr0 = front_q ? rmw_addr : rd_addr;
    assign raddr1 = front_q ? rd_addr : rmw_addr;

    fb_dp_ram u_bank0 (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (we0),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr0),
        .rdata_o (rdata0)
    );

    fb_dp_ram u_bank1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (we1),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr1),
        .rdata_o (rdata1)
    );

    assign rd_data    = rd_sel_q ? rdata1 : rdata0;
    assign cmd_ready  = ready_q;
    assign front_bank = front_q;
    assign frame_tick = tick_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer: a byte-level model of both banks feeds a queue of
// expected read data that is compared as the registered read port produces it.
module tb_frame_buffer;

    localparam logic [7:0] INIT = 8'h00;
    localparam logic [2:0] C_SET = 3'd0, C_CLR = 3'd1, C_TOG = 3'd2, C_FILL = 3'd3, C_SWAP = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [6:0] cmd_x = '0;
    logic [5:0] cmd_y = '0;
    logic [7:0] cmd_fill = '0;
    logic       front_bank, frame_tick, busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mbank [2][1024];
    logic       mfront;
    logic [7:0] exp_q [$];
    int         addr_q [$];

    frame_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_fill   (cmd_fill),
        .front_bank (front_bank),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_init();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 1024; i++) mbank[b][i] = INIT;
        end
        mfront = 1'b0;
    endtask

    // Drive addresses 0..1023, queue the model's front-bank byte, compare one cycle later.
    task automatic sweep(input string name);
        logic [7:0] e;
        int         a;
        for (int i = 0; i <= 1024; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                n_checks++;
                if (rd_data !== e)
                    $display("FAIL %s addr %0d: rd_data=%h required %h", name, a, rd_data, e);
                else n_pass++;
            end
            if (i < 1024) begin
                rd_addr = 10'(i);
                exp_q.push_back(mbank[mfront][i]);
                addr_q.push_back(i);
            end
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [6:0] x, input logic [5:0] y,
                            input logic [7:0] fv);
        int         waited = 0;
        int         nb, a;
        logic [7:0] m;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_fill  = fv;
        while (cmd_ready !== 1'b1 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL cmd_accept op %0d: cmd_ready=%b required 1", op, cmd_ready);
        else n_pass++;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        nb = mfront ? 0 : 1;
        a  = int'(x) * 8 + int'(y) / 8;
        m  = 8'd1 << (y % 8);
        case (op)
            C_SET:  mbank[nb][a] = mbank[nb][a] | m;
            C_CLR:  mbank[nb][a] = mbank[nb][a] & ~m;
            C_TOG:  mbank[nb][a] = mbank[nb][a] ^ m;
            C_FILL: for (int i = 0; i < 1024; i++) mbank[nb][i] = fv;
            default: ;
        endcase
    endtask

    // Walk rd_addr 1023 -> 0 after a SWAP was accepted; expect the tick then the toggle.
    task automatic boundary(input string name);
        @(negedge clk) rd_addr = 10'd1023;
        @(negedge clk) rd_addr = 10'd0;
        @(negedge clk);
        n_checks++;
        if (frame_tick !== 1'b1) $display("FAIL %s tick: frame_tick=%b required 1", name, frame_tick);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (front_bank !== ~mfront)
            $display("FAIL %s toggle: front_bank=%b required %b", name, front_bank, ~mfront);
        else n_pass++;
        mfront = ~mfront;
    endtask

    task automatic test_reset();
        int cnt = 0, bad = 0;
        model_init();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rd_data, cmd_ready, front_bank, frame_tick, busy} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_values: rd_data=%h ready=%b front=%b tick=%b busy=%b required 00 0 0 0 1",
                     rd_data, cmd_ready, front_bank, frame_tick, busy);
        else n_pass++;
        rst = 1'b0;
        while (busy === 1'b1 && cnt < 3000) begin
            if (cmd_ready !== 1'b0) bad++;
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 1024) $display("FAIL init_length: busy cycles=%0d required 1024", cnt);
        else n_pass++;
        n_checks++;
        if (bad != 0 || cmd_ready !== 1'b1 || front_bank !== 1'b0)
            $display("FAIL init_ready: early ready=%0d ready=%b front=%b required 0 1 0",
                     bad, cmd_ready, front_bank);
        else n_pass++;
        sweep("init_sweep");
    endtask

    task automatic test_set_swap();
        send_cmd(C_SET, 7'd5, 6'd10, 8'h00);
        send_cmd(C_SWAP, 7'd0, 6'd0, 8'h00);
        boundary("set_swap");
        rd_addr = 10'd41;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h04) $display("FAIL set_byte41: rd_data=%h required 04", rd_data);
        else n_pass++;
        sweep("set_sweep");
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = C_TOG;
        cmd_x     = 7'd5;
        cmd_y     = 6'd10;
        for (int i = 0; i < 6; i++) begin
            pat[i] = cmd_ready;
            if (i == 4) cmd_valid = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (pat !== 6'b001001) $display("FAIL b2b_ready_pattern: ready=%b required 001001", pat);
        else n_pass++;
        send_cmd(C_SWAP, 7'd0, 6'd0, 8'h00);
        boundary("b2b_swap");
        rd_addr = 10'd41;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h00) $display("FAIL b2b_byte41: rd_data=%h required 00", rd_data);
        else n_pass++;
        sweep("b2b_sweep");
    endtask

    task automatic test_fill_swap();
        int low = 0;
        send_cmd(C_FILL, 7'd0, 6'd0, 8'hA5);
        while (low < 3000) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) break;
            low++;
        end
        n_checks++;
        if (low != 1024) $display("FAIL fill_length: ready low=%0d required 1024", low);
        else n_pass++;
        send_cmd(C_SWAP, 7'd0, 6'd0, 8'h00);
        boundary("fill_swap");
        sweep("fill_sweep");
    endtask

    task automatic test_swap_hold();
        int rdy_seen = 0, tick_seen = 0;
        @(negedge clk) rd_addr = 10'd500;
        repeat (3) @(negedge clk);
        send_cmd(C_SWAP, 7'd0, 6'd0, 8'h00);
        repeat (20) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0) rdy_seen++;
        end
        rd_addr = 10'd0;
        repeat (4) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0) rdy_seen++;
            if (frame_tick !== 1'b0) tick_seen++;
        end
        n_checks++;
        if (rdy_seen != 0 || tick_seen != 0 || front_bank !== mfront)
            $display("FAIL swap_hold: ready highs=%0d ticks=%0d front=%b required 0 0 %b",
                     rdy_seen, tick_seen, front_bank, mfront);
        else n_pass++;
        boundary("swap_hold");
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL swap_ready: cmd_ready=%b required 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        int cnt = 0;
        send_cmd(C_SWAP, 7'd0, 6'd0, 8'h00);
        boundary("pre_reset_swap");
        send_cmd(C_FILL, 7'd0, 6'd0, 8'h3C);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rd_data, cmd_ready, front_bank, busy} !== {8'h00, 1'b0, 1'b0, 1'b1})
            $display("FAIL midfill_reset: rd_data=%h ready=%b front=%b busy=%b required 00 0 0 1",
                     rd_data, cmd_ready, front_bank, busy);
        else n_pass++;
        rst = 1'b0;
        model_init();
        while (busy === 1'b1 && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 1024) $display("FAIL reinit_length: busy cycles=%0d required 1024", cnt);
        else n_pass++;
        sweep("reinit_bank0");
        send_cmd(C_SWAP, 7'd0, 6'd0, 8'h00);
        boundary("reinit_swap");
        sweep("reinit_bank1");
    endtask

    initial begin
        test_reset();
        test_set_swap();
        test_back_to_back();
        test_fill_swap();
        test_swap_hold();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
